// File: rtl/carry_byte_serializer.sv
// carry_byte_serializer
// Buffers multi-byte bundles from the carry-propagation stage in a small
// FIFO and serializes them one byte per cycle over a valid/ready handshake.
// Run-length bundles (flags 5-7) are expanded into repeated bytes.
// Optional feature macro: SER_BYTE_COUNT_EN adds out_byte_count, a 32-bit
// wrapping count of accepted output bytes.
module carry_byte_serializer #(
  parameter int SER_BITSTREAM_WIDTH = 8,
  parameter int SER_FIFO_DEPTH      = 4,
  parameter int SER_FIFO_ADDR_WIDTH = 2
) (
  input  logic                           ser_clk,
  input  logic                           ser_reset,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
  input  logic [SER_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
  input  logic [2:0]                     in_carry_flag,
  input  logic                           in_flag_last,
  output logic                           in_ready,
  output logic [SER_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           out_error,
  output logic                           out_busy
`ifdef SER_BYTE_COUNT_EN
  ,
  output logic [31:0]                    out_byte_count
`endif
);

  localparam int W = SER_BITSTREAM_WIDTH;
  localparam int A = SER_FIFO_ADDR_WIDTH;
  localparam logic [A:0]   FULL_CNT = (A+1)'(SER_FIFO_DEPTH);
  localparam logic [A:0]   CNT_ONE  = (A+1)'(1);
  localparam logic [A-1:0] PTR_ONE  = A'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B1,
    ST_RUN,
    ST_LIN,
    ST_TAIL4,
    ST_TAIL5
  } state_t;

  // ST_LIN covers both b2 and b3 of the linear formats; lin2 selects b3
  typedef struct packed {
    state_t st;
    logic   lin2;
  } pos_t;

  typedef struct packed {
    logic [W-1:0] b1;
    logic [W-1:0] b2;
    logic [W-1:0] b3;
    logic [W-1:0] b4;
    logic [W-1:0] b5;
    logic [2:0]   flag;
    logic         last;
  } bundle_t;

  bundle_t    fifo_mem [SER_FIFO_DEPTH];
  logic [A-1:0] wr_ptr;
  logic [A-1:0] rd_ptr;
  logic [A:0]   fifo_count;
  logic         fifo_full;
  logic         push;
  logic         pop;
  bundle_t      head;
  bundle_t      head_next;

  pos_t         cur_pos;
  pos_t         nxt_pos;
  logic [15:0]  run_cnt;
  logic [15:0]  nxt_run;
  bundle_t      src;
  logic [W-1:0] nxt_byte;
  logic         nxt_valid;
  logic         nxt_last;
  logic         accept;

  // Position that follows cur within a bundle; ST_IDLE means the bundle is done.
  // run_left is the number of run bytes still owed after the current byte.
  function automatic pos_t succ(input pos_t cur, input logic [2:0] flag,
                                input logic [15:0] run_left);
    pos_t r;
    r.st   = ST_IDLE;
    r.lin2 = 1'b0;
    case (cur.st)
      ST_B1: begin
        if (flag == 3'd1) r.st = ST_IDLE;
        else if (flag <= 3'd4) r.st = ST_LIN;
        else if (run_left != 16'd0) r.st = ST_RUN;
        else if (flag != 3'd5) r.st = ST_TAIL4;
      end
      ST_RUN: begin
        if (run_left != 16'd0) r.st = ST_RUN;
        else if (flag != 3'd5) r.st = ST_TAIL4;
      end
      ST_LIN: begin
        if (!cur.lin2) begin
          if (flag != 3'd2) begin
            r.st   = ST_LIN;
            r.lin2 = 1'b1;
          end
        end else if (flag == 3'd4) begin
          r.st = ST_TAIL4;
        end
      end
      ST_TAIL4: begin
        if (flag == 3'd7) r.st = ST_TAIL5;
      end
      default: r.st = ST_IDLE;
    endcase
    return r;
  endfunction

  // Byte lane presented at a given position of a bundle
  function automatic logic [W-1:0] sel_byte(input pos_t p, input bundle_t b);
    logic [W-1:0] r;
    case (p.st)
      ST_B1:    r = b.b1;
      ST_RUN:   r = b.b2;
      ST_LIN:   r = p.lin2 ? b.b3 : b.b2;
      ST_TAIL4: r = b.b4;
      ST_TAIL5: r = b.b5;
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign fifo_full = (fifo_count == FULL_CNT);
  assign in_ready  = !fifo_full;
  assign push      = (in_carry_flag != 3'd0) && !fifo_full;
  assign head      = fifo_mem[rd_ptr];
  assign head_next = fifo_mem[rd_ptr + PTR_ONE];
  assign accept    = out_valid && out_ready;
  assign out_busy  = (fifo_count != '0) || (cur_pos.st != ST_IDLE);

  // Bundle storage; no reset needed since occupancy gates every read
  always_ff @(posedge ser_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{b1: in_carry_bit_1, b2: in_carry_bit_2,
                            b3: in_carry_bit_3, b4: in_carry_bit_4,
                            b5: in_carry_bit_5, flag: in_carry_flag,
                            last: in_flag_last};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge ser_clk or negedge ser_reset) begin
    if (!ser_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_error  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
      else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
      if ((in_carry_flag != 3'd0) && fifo_full) out_error <= 1'b1;
    end
  end

  // State register together with the registered output byte/valid/last
  always_ff @(posedge ser_clk or negedge ser_reset) begin
    if (!ser_reset) begin
      cur_pos   <= '{st: ST_IDLE, lin2: 1'b0};
      run_cnt   <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      cur_pos   <= nxt_pos;
      run_cnt   <= nxt_run;
      out_byte  <= nxt_byte;
      out_valid <= nxt_valid;
      out_last  <= nxt_last;
    end
  end

  // Next position: start a bundle from IDLE, step on acceptance, and chain
  // straight into the following bundle's b1 when one is already queued
  always_comb begin
    nxt_pos = cur_pos;
    nxt_run = run_cnt;
    pop     = 1'b0;
    src     = head;
    if (cur_pos.st == ST_IDLE) begin
      if (fifo_count != '0) begin
        nxt_pos = '{st: ST_B1, lin2: 1'b0};
        nxt_run = 16'(head.b3);
      end
    end else if (accept) begin
      nxt_pos = succ(cur_pos, head.flag, run_cnt);
      if (nxt_pos.st == ST_RUN) nxt_run = run_cnt - 16'd1;
      if (nxt_pos.st == ST_IDLE) begin
        pop = 1'b1;
        if (fifo_count > CNT_ONE) begin
          src     = head_next;
          nxt_pos = '{st: ST_B1, lin2: 1'b0};
          nxt_run = 16'(head_next.b3);
        end
      end
    end
  end

  // Output values for the next position; last marks the bundle's final byte
  always_comb begin
    nxt_valid = (nxt_pos.st != ST_IDLE);
    nxt_byte  = sel_byte(nxt_pos, src);
    nxt_last  = 1'b0;
    if (nxt_valid && src.last) begin
      nxt_last = (succ(nxt_pos, src.flag, nxt_run).st == ST_IDLE);
    end
  end

`ifdef SER_BYTE_COUNT_EN
  // Running count of accepted bytes, wrapping naturally at 2^32
  always_ff @(posedge ser_clk or negedge ser_reset) begin
    if (!ser_reset) out_byte_count <= '0;
    else if (accept) out_byte_count <= out_byte_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_carry_byte_serializer.sv
// tb_carry_byte_serializer
// Directed table of bundle formats plus hand-written sequences for
// back-to-back chaining, overflow, random backpressure and mid-run reset.
module tb_carry_byte_serializer;

  logic        ser_clk;
  logic        ser_reset;
  logic [7:0]  in_carry_bit_1, in_carry_bit_2, in_carry_bit_3;
  logic [7:0]  in_carry_bit_4, in_carry_bit_5;
  logic [2:0]  in_carry_flag;
  logic        in_flag_last;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_error;
  logic        out_busy;
`ifdef SER_BYTE_COUNT_EN
  logic [31:0] out_byte_count;
`endif

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [2:0] flag;
    logic [7:0] b1, b2, b3, b4, b5;
    logic       last;
    int         n;
    logic [7:0] exp [8];
  } vec_t;

  vec_t vecs [8];
  logic [8:0] exp_q [$];

  carry_byte_serializer dut (
    .ser_clk        (ser_clk),
    .ser_reset      (ser_reset),
    .in_carry_bit_1 (in_carry_bit_1),
    .in_carry_bit_2 (in_carry_bit_2),
    .in_carry_bit_3 (in_carry_bit_3),
    .in_carry_bit_4 (in_carry_bit_4),
    .in_carry_bit_5 (in_carry_bit_5),
    .in_carry_flag  (in_carry_flag),
    .in_flag_last   (in_flag_last),
    .in_ready       (in_ready),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .out_error      (out_error),
    .out_busy       (out_busy)
`ifdef SER_BYTE_COUNT_EN
    ,
    .out_byte_count (out_byte_count)
`endif
  );

  // 10-unit clock
  initial ser_clk = 1'b0;
  always #5 ser_clk = ~ser_clk;

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge ser_clk);
    #1;
  endtask

  // Present one bundle for a single cycle; called #1 after a clock edge
  task automatic apply_stimulus(input logic [2:0] f, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input logic [7:0] e,
                                input logic l);
    in_carry_flag  = f;
    in_carry_bit_1 = a;
    in_carry_bit_2 = b;
    in_carry_bit_3 = c;
    in_carry_bit_4 = d;
    in_carry_bit_5 = e;
    in_flag_last   = l;
    step();
    in_carry_flag  = 3'd0;
  endtask

  task automatic do_reset();
    ser_reset = 1'b0;
    repeat (2) @(posedge ser_clk);
    #1;
    ser_reset = 1'b1;
  endtask

  // Collect v.n bytes with out_ready high; bytes after the first must be gapless
  task automatic collect_bytes(input string tag, input vec_t v, output int first_wait);
    int w;
    first_wait = -1;
    for (int i = 0; i < v.n; i++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        step();
        w++;
      end
      if (i == 0) first_wait = w;
      else check_output($sformatf("%s gap before byte %0d", tag, i), w, 0);
      check_output($sformatf("%s valid %0d", tag, i), {31'b0, out_valid}, 1);
      check_output($sformatf("%s byte %0d", tag, i), {24'b0, out_byte}, {24'b0, v.exp[i]});
      check_output($sformatf("%s last %0d", tag, i), {31'b0, out_last},
                   {31'b0, v.last && (i == v.n - 1)});
      step();
    end
  endtask

  // Reference expansion of one bundle into {last, byte} entries
  task automatic model_expand(input logic [2:0] f, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] e,
                              input logic l);
    logic [7:0] bytes [$];
    bytes.push_back(a);
    if (f >= 3'd2 && f <= 3'd4) bytes.push_back(b);
    if (f == 3'd3 || f == 3'd4) bytes.push_back(c);
    if (f == 3'd4) bytes.push_back(d);
    if (f >= 3'd5) for (int k = 0; k < int'(c); k++) bytes.push_back(b);
    if (f >= 3'd6) bytes.push_back(d);
    if (f == 3'd7) bytes.push_back(e);
    foreach (bytes[k]) exp_q.push_back({l && (k == bytes.size() - 1), bytes[k]});
  endtask

  initial begin
    int fw;
    vec_t seq;
    logic [8:0] held;
    logic [8:0] front;
    logic stalled;
    int sent;
    int cycles;
    logic [2:0] rf;
    logic [7:0] ra, rb, rc, rd, re;
    logic rl;

    vecs[0] = '{3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0, 3,
                '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{3'd7, 8'hA0, 8'hFF, 8'h03, 8'h01, 8'h02, 1'b1, 6,
                '{8'hA0, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'h00}};
    vecs[2] = '{3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1,
                '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{3'd2, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 1'b0, 2,
                '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{3'd4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b1, 4,
                '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{3'd6, 8'hC1, 8'hC2, 8'h02, 8'hC4, 8'hC5, 1'b1, 4,
                '{8'hC1, 8'hC2, 8'hC2, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{3'd6, 8'hD1, 8'hD2, 8'h00, 8'hD4, 8'hD5, 1'b0, 2,
                '{8'hD1, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[7] = '{3'd5, 8'hE1, 8'hE2, 8'h02, 8'hE4, 8'hE5, 1'b1, 3,
                '{8'hE1, 8'hE2, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

    ser_reset      = 1'b0;
    in_carry_flag  = 3'd0;
    in_carry_bit_1 = 8'h00;
    in_carry_bit_2 = 8'h00;
    in_carry_bit_3 = 8'h00;
    in_carry_bit_4 = 8'h00;
    in_carry_bit_5 = 8'h00;
    in_flag_last   = 1'b0;
    out_ready      = 1'b1;

    // Reset values while reset is held
    #3;
    check_output("reset out_valid", {31'b0, out_valid}, 0);
    check_output("reset out_byte", {24'b0, out_byte}, 0);
    check_output("reset out_last", {31'b0, out_last}, 0);
    check_output("reset out_error", {31'b0, out_error}, 0);
    check_output("reset out_busy", {31'b0, out_busy}, 0);
    check_output("reset in_ready", {31'b0, in_ready}, 1);
    do_reset();

    // Table: one bundle at a time into an empty block, ready held high
    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].flag, vecs[v].b1, vecs[v].b2, vecs[v].b3,
                     vecs[v].b4, vecs[v].b5, vecs[v].last);
      collect_bytes($sformatf("vec%0d", v), vecs[v], fw);
      check_output($sformatf("vec%0d latency", v), fw, 1);
      check_output($sformatf("vec%0d idle valid", v), {31'b0, out_valid}, 0);
      check_output($sformatf("vec%0d idle busy", v), {31'b0, out_busy}, 0);
`ifdef SER_BYTE_COUNT_EN
      if (v == 0) check_output("byte count after vec0", out_byte_count, 3);
`endif
    end

    // Flag 5 with zero run count, next bundle chained without a gap
    apply_stimulus(3'd5, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 1'b0);
    apply_stimulus(3'd1, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    seq = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2,
            '{8'h31, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    collect_bytes("chain", seq, fw);
    check_output("chain idle valid", {31'b0, out_valid}, 0);

    // Overflow: five single-byte bundles into four slots while stalled
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      apply_stimulus(3'd1, 8'h60 + 8'(k), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("full in_ready", {31'b0, in_ready}, 0);
    check_output("full no error yet", {31'b0, out_error}, 0);
    apply_stimulus(3'd1, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_output("overflow out_error", {31'b0, out_error}, 1);
    check_output("stall holds byte", {23'b0, out_valid, out_byte}, 32'h160);
    out_ready = 1'b1;
    seq = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4,
            '{8'h60, 8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00}};
    collect_bytes("drain", seq, fw);
    check_output("drain exactly four", {31'b0, out_valid}, 0);
    check_output("error sticky", {31'b0, out_error}, 1);

    // Random bundles under random backpressure against the reference model
    do_reset();
    stalled = 1'b0;
    held    = '0;
    sent    = 0;
    cycles  = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cycles < 40000) begin
      if (stalled)
        check_output("stall stable", {22'b0, out_valid, out_last, out_byte},
                     {22'b0, 1'b1, held});
      out_ready = ($urandom_range(0, 3) != 0);
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check_output("random extra byte", {23'b0, out_last, out_byte}, 32'h1FF);
          end else begin
            front = exp_q.pop_front();
            check_output("random byte", {23'b0, out_last, out_byte}, {23'b0, front});
          end
        end else begin
          stalled = 1'b1;
          held    = {out_last, out_byte};
        end
      end
      if (sent < 1000 && in_ready && $urandom_range(0, 1) == 1) begin
        rf = 3'($urandom_range(1, 7));
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = (rf >= 3'd5) ? 8'($urandom_range(0, 5)) : 8'($urandom);
        rd = 8'($urandom);
        re = 8'($urandom);
        rl = 1'($urandom_range(0, 1));
        in_carry_flag  = rf;
        in_carry_bit_1 = ra;
        in_carry_bit_2 = rb;
        in_carry_bit_3 = rc;
        in_carry_bit_4 = rd;
        in_carry_bit_5 = re;
        in_flag_last   = rl;
        model_expand(rf, ra, rb, rc, rd, re, rl);
        sent++;
      end else begin
        in_carry_flag = 3'd0;
      end
      step();
      cycles++;
    end
    in_carry_flag = 3'd0;
    check_output("random all bytes seen", exp_q.size(), 0);
    check_output("random no overflow", {31'b0, out_error}, 0);

    // Reset in the middle of a long run bundle
    out_ready = 1'b1;
    apply_stimulus(3'd6, 8'h71, 8'h72, 8'd10, 8'h74, 8'h00, 1'b1);
    repeat (4) step();
    check_output("midrun active", {31'b0, out_valid}, 1);
    ser_reset = 1'b0;
    #1;
    check_output("midrun reset valid", {31'b0, out_valid}, 0);
    check_output("midrun reset byte", {24'b0, out_byte}, 0);
    check_output("midrun reset last", {31'b0, out_last}, 0);
    check_output("midrun reset busy", {31'b0, out_busy}, 0);
    check_output("midrun reset in_ready", {31'b0, in_ready}, 1);
`ifdef SER_BYTE_COUNT_EN
    check_output("midrun reset byte count", out_byte_count, 0);
`endif
    #3;
    ser_reset = 1'b1;
    repeat (3) step();
    check_output("after reset no output", {31'b0, out_valid}, 0);
    check_output("after reset not busy", {31'b0, out_busy}, 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
